// File: rtl/fpu_sched_pkg.sv
// Shared types and encodings for the FPU job scheduler.
package fpu_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RESP    = 3'd3,
    ST_RECOVER = 3'd4
  } state_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_FMA = 2'b11;

  localparam int unsigned FLAG_INVALID   = 0;
  localparam int unsigned FLAG_OVERFLOW  = 1;
  localparam int unsigned FLAG_UNDERFLOW = 2;
  localparam int unsigned FLAG_INEXACT   = 3;

  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic [1:0]        op;
    logic [1:0]        fmt;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] c;
  } fpu_job_t;

  function automatic int unsigned timer_width(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/fpu_job_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester after last_grant wins.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  int unsigned   idx;
  logic [IW-1:0] cidx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    cidx      = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx  = (32'(last_grant) + k) % N;
      cidx = IW'(idx);
      if (!any && req[cidx]) begin
        any        = 1'b1;
        grant[cidx] = 1'b1;
        grant_idx  = cidx;
      end
    end
  end

endmodule

// File: rtl/fpu_job_scheduler.sv
// Arbitrates requesters onto one FPU lane, issues jobs, returns results,
// and recovers the FPU with a reset pulse if it never completes.
module fpu_job_scheduler
  import fpu_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned RST_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [2*NUM_REQ-1:0]    req_op,
  input  logic [2*NUM_REQ-1:0]    req_fmt,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
  input  logic [32*NUM_REQ-1:0]   req_c,
  output logic [NUM_REQ-1:0]      resp_valid,
  output logic [31:0]             resp_data,
  output logic [3:0]              resp_flags,
  output logic                    resp_timeout,
  output logic                    fpu_en,
  output logic                    fpu_rst_w,
  output logic                    fpu_doorbell_w,
  output logic [1:0]              fpu_operation,
  output logic [1:0]              fpu_format,
  output logic                    fpu_fused_m_a,
  output logic [31:0]             fpu_operand_a,
  output logic [31:0]             fpu_operand_b,
  output logic [31:0]             fpu_operand_c,
  input  logic [31:0]             fpu_output,
  input  logic                    fpu_invalid_op_flag_0,
  input  logic                    fpu_overflow_flag_0,
  input  logic                    fpu_underflow_flag_0,
  input  logic                    fpu_inexact_flag_0,
  input  logic                    fpu_ready
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned TW = timer_width(TIMEOUT);
  localparam int unsigned RW = $clog2(RST_CYCLES + 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  state_e              state_q, state_d;
  fpu_job_t            job_q, job_d;
  logic                fused_q, fused_d;
  logic [IW-1:0]       last_q, last_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [RW-1:0]       rcnt_q, rcnt_d;
  logic                ready_q;
  logic [31:0]         rdata_q, rdata_d;
  logic [3:0]          rflags_q, rflags_d;
  logic                rto_q, rto_d;
  logic [NUM_REQ-1:0]  rvalid_q, rvalid_d;
  logic                bell_q, bell_d;
  logic                frst_q, frst_d;
  logic                en_q;

  fpu_job_t            job_arr [NUM_REQ];
  logic [NUM_REQ-1:0]  grant;
  logic [IW-1:0]       gidx;
  logic                any;
  logic                accept;
  logic [3:0]          fpu_flags;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign job_arr[i] = '{op:  req_op[2*i+1:2*i],
                          fmt: req_fmt[2*i+1:2*i],
                          a:   req_a[32*i+31:32*i],
                          b:   req_b[32*i+31:32*i],
                          c:   req_c[32*i+31:32*i]};
  end

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req        (req_valid),
    .last_grant (last_q),
    .grant      (grant),
    .grant_idx  (gidx),
    .any        (any)
  );

  // Grants are held off until the block has left reset for a clock.
  assign accept    = (state_q == ST_IDLE) && en_q && any;
  assign req_ready = accept ? grant : '0;

  always_comb begin
    fpu_flags                 = '0;
    fpu_flags[FLAG_INVALID]   = fpu_invalid_op_flag_0;
    fpu_flags[FLAG_OVERFLOW]  = fpu_overflow_flag_0;
    fpu_flags[FLAG_UNDERFLOW] = fpu_underflow_flag_0;
    fpu_flags[FLAG_INEXACT]   = fpu_inexact_flag_0;
  end

  always_comb begin
    state_d  = state_q;
    job_d    = job_q;
    fused_d  = fused_q;
    last_d   = last_q;
    timer_d  = timer_q;
    rcnt_d   = rcnt_q;
    rdata_d  = rdata_q;
    rflags_d = rflags_q;
    rto_d    = rto_q;
    rvalid_d = '0;
    bell_d   = 1'b0;
    frst_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          job_d   = job_arr[gidx];
          fused_d = (job_arr[gidx].op == OP_FMA);
          last_d  = gidx;
          bell_d  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Only a fresh rising edge of fpu_ready completes the job.
        if (fpu_ready && !ready_q) begin
          rdata_d  = fpu_output;
          rflags_d = fpu_flags;
          rto_d    = 1'b0;
          rvalid_d = ONE_HOT0 << last_q;
          state_d  = ST_RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          rcnt_d  = '0;
          frst_d  = 1'b1;
          state_d = ST_RECOVER;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_RECOVER: begin
        rdata_d  = '0;
        rflags_d = '0;
        rto_d    = 1'b1;
        if (rcnt_q == RW'(RST_CYCLES - 1)) begin
          rvalid_d = ONE_HOT0 << last_q;
          state_d  = ST_RESP;
        end else begin
          rcnt_d = rcnt_q + RW'(1);
          frst_d = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      job_q    <= '0;
      fused_q  <= 1'b0;
      last_q   <= IW'(NUM_REQ - 1);
      timer_q  <= '0;
      rcnt_q   <= '0;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      rflags_q <= '0;
      rto_q    <= 1'b0;
      rvalid_q <= '0;
      bell_q   <= 1'b0;
      frst_q   <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      job_q    <= job_d;
      fused_q  <= fused_d;
      last_q   <= last_d;
      timer_q  <= timer_d;
      rcnt_q   <= rcnt_d;
      ready_q  <= fpu_ready;
      rdata_q  <= rdata_d;
      rflags_q <= rflags_d;
      rto_q    <= rto_d;
      rvalid_q <= rvalid_d;
      bell_q   <= bell_d;
      frst_q   <= frst_d;
      en_q     <= 1'b1;
    end
  end

  assign resp_valid     = rvalid_q;
  assign resp_data      = rdata_q;
  assign resp_flags     = rflags_q;
  assign resp_timeout   = rto_q;
  assign fpu_en         = en_q;
  assign fpu_rst_w      = frst_q;
  assign fpu_doorbell_w = bell_q;
  assign fpu_operation  = job_q.op;
  assign fpu_format     = job_q.fmt;
  assign fpu_fused_m_a  = fused_q;
  assign fpu_operand_a  = job_q.a;
  assign fpu_operand_b  = job_q.b;
  assign fpu_operand_c  = job_q.c;

endmodule
